serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports clk and rst; all state SHALL change on the rising edge of clk only.
REQ-002 The block SHALL have parameter WIDTH, default 8: operand and result width in bits; legal range 1..32.
REQ-003 Port clk, input, 1 bit: system clock.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port start, input, 1 bit: request to begin an addition; sampled on the rising edge.
REQ-006 Port din_one, input, WIDTH bits: first operand; sampled only when start is accepted.
REQ-007 Port din_two, input, WIDTH bits: second operand; sampled only when start is accepted.
REQ-008 Port cin, input, 1 bit: carry-in; sampled only when start is accepted.
REQ-009 Port busy, output, 1 bit: high while an addition is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-011 Port sum, output, WIDTH bits: registered result.
REQ-012 Port cout, output, 1 bit: registered final carry.

Function
REQ-013 The FSM SHALL have two states, IDLE and RUN; busy SHALL equal (state == RUN).
REQ-014 In IDLE with start=1, the block SHALL load the operands into shift registers, load the carry register with cin, clear the bit counter, and enter RUN.
REQ-015 start SHALL be ignored while in RUN; operands SHALL not be re-sampled.
REQ-016 Each RUN cycle SHALL add operand LSBs and the carry register in one full-adder cell, shift the sum bit into the result shift register MSB-first, shift both operands right by one, store the cell carry, and increment the counter.
REQ-017 After exactly WIDTH RUN cycles, the block SHALL return to IDLE; the same edge SHALL load sum and cout and assert done for one cycle.
REQ-018 If start is sampled at edge t, busy SHALL be high after edges t..t+WIDTH-1, and done SHALL be high for the single cycle after edge t+WIDTH.
REQ-019 sum and cout SHALL hold the previous result throughout RUN and until the next completion; partial results SHALL never be visible.
REQ-020 start=1 in the done cycle SHALL be accepted, giving back-to-back operations of WIDTH+1 cycles each.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH: {cout,sum} = din_one + din_two + cin.
REQ-022 With WIDTH=1, the block SHALL complete one cycle after start.

Reset
REQ-023 With rst=1, at the edge the block SHALL set state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, and clear all shift and carry registers; rst SHALL override start.
REQ-024 Reset during RUN SHALL abort the operation, with no done pulse and no result update.

Configuration
REQ-025 With macro SERIAL_ADDER_OVF_EN defined, the block SHALL add output port ovf (1 bit): signed two's-complement overflow (carry into MSB XOR carry out of MSB), registered with sum, reset to 0.
REQ-026 With SERIAL_ADDER_OVF_EN undefined, port ovf and its logic SHALL be absent, with all other behaviour identical.

Structure
REQ-027 The state encodings (IDLE=1'b0, RUN=1'b1) and the counter-width function (clog2 of WIDTH, minimum 1) SHALL live in the shared package serial_adder_pkg.
REQ-028 The per-bit addition SHALL instantiate the existing combinational cell adder_1bit once (inputs din_one, din_two, cin; outputs sum, cout), rather than duplicating its logic.

Verification
REQ-029 Basic add: WIDTH=8, 0x5A + 0x3C, cin=0, start at edge t -> done after edge t+8, sum=0x96, cout=0.
REQ-030 Carry chain: 0xFF + 0x01 with cin=0 -> sum=0x00, cout=1; 0xFF + 0x00 with cin=1 -> sum=0x00, cout=1.
REQ-031 Start while busy: start pulsed at t+3 with different operands -> ignored; result of the first operation only, exactly one done.
REQ-032 Reset mid-run: rst at t+4 -> next cycle busy=0, sum=0, cout=0; no done for 10 cycles.
REQ-033 Back-to-back: start held high through the done cycle -> second result 9 cycles after the first; sum stable between the two done pulses.
REQ-034 Overflow (SERIAL_ADDER_OVF_EN defined): 0x7F + 0x01 -> sum=0x80, ovf=1; 0xFF + 0x01 -> ovf=0, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit counter width: clog2 of the operand width, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_cell.sv
// Combinational one-bit full-adder cell, used one bit per cycle by serial_adder.
module adder_1bit (
  input  logic din_one,
  input  logic din_two,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = din_one ^ din_two ^ cin;
  assign cout = (din_one & din_two) | (cin & (din_one ^ din_two));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell, WIDTH run cycles per addition.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din_one,
  input  logic [WIDTH-1:0] din_two,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             cell_sum;
  logic             cell_cout;
  logic [WIDTH-1:0] res_shift;

  adder_1bit u_cell (
    .din_one (a_q[0]),
    .din_two (b_q[0]),
    .cin     (carry_q),
    .sum     (cell_sum),
    .cout    (cell_cout)
  );

  // New sum bit enters at the MSB, so after WIDTH cycles bit 0 holds the first one.
  assign res_shift = (res_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = din_one;
          b_d     = din_two;
          carry_d = cin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = cell_cout;
        res_d   = res_shift;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_d = IDLE;
          sum_d   = res_shift;
          cout_d  = cell_cout;
          done_d  = 1'b1;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB cell on this final cycle
          ovf_d   = carry_q ^ cell_cout;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed corner cases plus random adds against an arithmetic model.
// Define SERIAL_ADDER_OVF_EN for both bench and RTL to exercise the ovf output.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] din_one;
  logic [W-1:0] din_two;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  // Expected {ovf, cout, sum} per accepted start, oldest first.
  logic [W+1:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  bit seen_reset = 0;
  logic [W-1:0] last_sum;
  logic         last_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .din_one (din_one),
    .din_two (din_two),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: timeout actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference model from the arithmetic definition, not from the bit-serial datapath.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0]   full;
    logic signed [W+1:0] s_sum;
    logic         v;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s_sum = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({{(W+1){1'b0}}, c});
    v     = (s_sum > $signed((W+2)'((1 << (W - 1)) - 1))) ||
            (s_sum < -$signed((W+2)'(1 << (W - 1))));
    return {v, full};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    logic rst_at_edge;
    logic [W+1:0] e;
    rst_at_edge = rst;
    cyc++;
    #1;
    if (rst_at_edge) begin
      seen_reset = 1;
      exp_q.delete();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", ovf, 0);
`endif
      last_sum  = '0;
      last_cout = 1'b0;
    end else if (seen_reset && done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e[W-1:0]);
        check("cout", cout, e[W]);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf, e[W+1]);
`endif
        check("busy_at_done", busy, 0);
      end
      last_sum  = sum;
      last_cout = cout;
    end else if (seen_reset) begin
      if (sum !== last_sum) check("sum_hold", sum, last_sum);
      if (cout !== last_cout) check("cout_hold", cout, last_cout);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic scramble_inputs();
    din_one = W'($urandom);
    din_two = W'($urandom);
    cin     = 1'($urandom);
  endtask

  // Wait for the next done pulse after n0 pulses; returns the cycles since start edge t0.
  task automatic wait_done(input int n0, input int t0, output int lat);
    for (int k = 0; k < W + 6 && done_cnt == n0; k++) tick();
    if (done_cnt == n0) begin
      check("done_timeout", 0, 1);
      lat = -1;
    end else begin
      lat = last_done_cyc - t0;
    end
  endtask

  // Full addition from idle: checks busy window and exact done latency.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int t0, n0, lat;
    bit busy_ok;
    din_one = a;
    din_two = b;
    cin     = c;
    start   = 1'b1;
    exp_q.push_back(model(a, b, c));
    tick();
    start = 1'b0;
    t0 = cyc;
    n0 = done_cnt;
    busy_ok = 1;
    for (int k = 0; k < W - 1; k++) begin
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
      scramble_inputs();
      tick();
    end
    if (busy !== 1'b1 || done !== 1'b0) busy_ok = 0;
    check("busy_window", busy_ok, 1);
    wait_done(n0, t0, lat);
    check("done_latency", lat, W);
    tick();
    check("done_one_cycle", done, 0);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0, n0, lat, d1;
    rst   = 1'b1;
    start = 1'b0;
    din_one = '0;
    din_two = '0;
    cin   = 1'b0;
    apply_reset(2);

    // Directed arithmetic
    do_add(8'h5A, 8'h3C, 1'b0);
    do_add(8'hFF, 8'h01, 1'b0);
    do_add(8'hFF, 8'h00, 1'b1);
    do_add(8'h7F, 8'h01, 1'b0);
    do_add(8'h80, 8'h80, 1'b0);
    do_add(8'h00, 8'h00, 1'b0);
    do_add(8'hFF, 8'hFF, 1'b1);

    // Start pulse while busy must be ignored
    din_one = 8'h12; din_two = 8'h34; cin = 1'b1; start = 1'b1;
    exp_q.push_back(model(8'h12, 8'h34, 1'b1));
    tick();
    start = 1'b0;
    t0 = cyc;
    n0 = done_cnt;
    tick(); tick();
    din_one = 8'hEE; din_two = 8'hDD; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n0, t0, lat);
    check("busy_start_latency", lat, W);
    repeat (12) tick();
    check("busy_start_done_count", done_cnt - n0, 1);

    // Reset in the middle of a run
    din_one = 8'hA5; din_two = 8'h5A; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n0 = done_cnt;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    repeat (10) tick();
    check("abort_no_done", done_cnt - n0, 0);

    // Back-to-back with start held through the done cycle
    din_one = 8'h11; din_two = 8'h22; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h11, 8'h22, 1'b0));
    tick();
    t0 = cyc;
    n0 = done_cnt;
    din_one = 8'hC8; din_two = 8'h64; cin = 1'b1;
    exp_q.push_back(model(8'hC8, 8'h64, 1'b1));
    wait_done(n0, t0, lat);
    check("b2b_first_latency", lat, W);
    d1 = last_done_cyc;
    tick();
    start = 1'b0;
    scramble_inputs();
    wait_done(n0 + 1, d1, lat);
    check("b2b_spacing", lat, W + 1);
    tick();

    // Random operations from idle
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      logic c;
      a = W'($urandom);
      b = W'($urandom_range(0, (1 << W) - 1));
      c = 1'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      do_add(a, b, c);
    end

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
